guess_evaluator: RTL and testbench
==================================

# guess_evaluator

Sequential control stage wrapped around the 4-bit magnitude comparator in the number-guessing datapath. It latches a secret and successive player guesses into registers, which drive the comparator operands. It samples the comparator's eq/gt/lt outputs one cycle later. It then counts attempts and produces registered win/lose/hint results for the display stage.

## Interface
- MAX_TRIES, 7, number of guesses allowed per round; legal range 1..15.
- clk  in  1  rising-edge system clock.
- rst  in  1  reset; asynchronous, active-high.
- load_secret  in  1  one-cycle strobe that starts a new round with secret_in.
- secret_in  in  4  secret value, sampled when load_secret=1.
- guess_valid  in  1  one-cycle strobe presenting a guess.
- guess_in  in  4  guess value, sampled when guess_valid is accepted.
- cmp_a  out  4  comparator operand a (registered guess).
- cmp_b  out  4  comparator operand b (registered secret).
- cmp_eq, cmp_gt, cmp_lt  in  1 each  comparator results for a vs b (combinational from cmp_a/cmp_b).
- busy  out  1  high in COMPARE; guesses are not accepted.
- result_valid  out  1  one-cycle pulse when a guess has been evaluated.
- hint_high  out  1  last guess > secret.
- hint_low  out  1  last guess < secret.
- win  out  1  round won; held until the next load_secret.
- lose  out  1  tries exhausted without a match; held until the next load_secret.
- tries  out  4  guesses evaluated this round.
- cmp_err  out  1  sticky; comparator outputs were not exactly one-hot when sampled.

## Operation
- States: IDLE, ARMED, COMPARE, DONE.
- IDLE: waits for load_secret. guess_valid is ignored.
- load_secret (any state except during reset) has top priority:
  - secret register <- secret_in; guess register <- 0.
  - tries, win, lose, hints and cmp_err are cleared; result_valid = 0.
  - Next state is ARMED.
- ARMED: on guess_valid, the guess register <- guess_in and the FSM goes to COMPARE.
- COMPARE: busy=1; guess_valid is ignored and dropped, not queued. Evaluate once, then:
  - tries <- tries+1 and result_valid pulses.
  - hint_high <- cmp_gt; hint_low <- cmp_lt.
  - If cmp_eq: win <- 1, next state DONE.
  - Else if tries+1 == MAX_TRIES: lose <- 1, next state DONE.
  - Else: next state ARMED.
- Malformed comparator output (eq+gt+lt != 1):
  - cmp_err is set.
  - The guess is treated as a miss: hints from cmp_gt/cmp_lt as sampled, no win.
- DONE: holds all outputs. guess_valid is ignored. Only load_secret leaves DONE.
- tries is 4-bit and cannot wrap because MAX_TRIES ≤ 15.
- Hints keep the last evaluated value until the next evaluation or load_secret. On a win, both hints are 0.

## Timing
- Reset values: state IDLE; cmp_a=0, cmp_b=0, tries=0; busy, result_valid, hint_high, hint_low, win, lose and cmp_err all 0.
- Reset mid-round aborts the round immediately (asynchronously); no result pulse is produced.
- load_secret sampled at edge E: cmp_b is valid after E, and the FSM is ARMED in the following cycle.
- guess_valid sampled in ARMED at edge E:
  - cmp_a is updated after E.
  - busy is high for one cycle; the comparator settles during that cycle.
  - The results register at edge E+1, so result_valid/win/lose/hints/tries are visible in the cycle after E+1.
  - Latency is 2 cycles, guess strobe to result.
- Maximum throughput is one guess every 2 cycles. A guess_valid in the cycle right after a result (state ARMED again) is accepted.
- Simultaneous load_secret and guess_valid: load_secret wins and the guess is discarded.
- load_secret arriving in COMPARE: the pending evaluation is abandoned; there is no result_valid and tries is not incremented.

## Test plan
- Reset then load_secret with 4'd9; guess 4'd9 -> 2 cycles later result_valid=1, win=1, tries=1, hint_high=0, hint_low=0, state DONE; a further guess_valid causes no change.
- Secret 4'd5; guesses 12, 2, 5 -> hint_high=1 on the first result, hint_low=1 on the second, win on the third; tries=3; lose=0.
- MAX_TRIES=3, secret 4'd0; guesses 1, 2, 3 -> lose=1 on the third result, tries=3, win=0; a later load_secret clears both.
- guess_valid asserted in the busy cycle and simultaneously with load_secret -> both are dropped; tries is unchanged and no extra result_valid occurs.
- Comparator model forced to eq=gt=1 -> cmp_err=1 (sticky), win=0, tries increments; the next load_secret clears cmp_err.
- Assert rst during COMPARE -> all outputs are 0 immediately and the FSM is IDLE; guesses are ignored until load_secret.

Source files
------------

// File: rtl/guess_evaluator.sv
// guess_evaluator: control stage around an external 4-bit magnitude comparator.
// Latches the secret and each guess onto the comparator operands, samples
// eq/gt/lt one cycle later, counts attempts and produces registered
// win/lose/hint results for the display stage.
`timescale 1ns/1ps
module guess_evaluator #(
  parameter int MAX_TRIES = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_secret,
  input  logic [3:0] secret_in,
  input  logic       guess_valid,
  input  logic [3:0] guess_in,
  output logic [3:0] cmp_a,
  output logic [3:0] cmp_b,
  input  logic       cmp_eq,
  input  logic       cmp_gt,
  input  logic       cmp_lt,
  output logic       busy,
  output logic       result_valid,
  output logic       hint_high,
  output logic       hint_low,
  output logic       win,
  output logic       lose,
  output logic [3:0] tries,
  output logic       cmp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t     state_q;
  logic [3:0] guess_q;
  logic [3:0] secret_q;
  logic [3:0] tries_q;
  logic       busy_q;
  logic       rv_q;
  logic       hint_high_q;
  logic       hint_low_q;
  logic       win_q;
  logic       lose_q;
  logic       err_q;

  logic [3:0] tries_d;
  logic       last_try_d;
  logic       onehot_d;

  // True when exactly one of the three comparator flags is set.
  function automatic logic is_onehot3(input logic e, input logic g, input logic l);
    return (e & ~g & ~l) | (~e & g & ~l) | (~e & ~g & l);
  endfunction

  // Attempt count after this evaluation and comparator sanity.
  always_comb begin
    tries_d    = tries_q + 4'd1;
    last_try_d = (({1'b0, tries_q} + 5'd1) == 5'(MAX_TRIES));
    onehot_d   = is_onehot3(cmp_eq, cmp_gt, cmp_lt);
  end

  // Round control FSM with all outputs registered; load_secret overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      guess_q     <= 4'd0;
      secret_q    <= 4'd0;
      tries_q     <= 4'd0;
      busy_q      <= 1'b0;
      rv_q        <= 1'b0;
      hint_high_q <= 1'b0;
      hint_low_q  <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (load_secret) begin
        secret_q    <= secret_in;
        guess_q     <= 4'd0;
        tries_q     <= 4'd0;
        busy_q      <= 1'b0;
        hint_high_q <= 1'b0;
        hint_low_q  <= 1'b0;
        win_q       <= 1'b0;
        lose_q      <= 1'b0;
        err_q       <= 1'b0;
        state_q     <= S_ARMED;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_ARMED: begin
            if (guess_valid) begin
              guess_q <= guess_in;
              busy_q  <= 1'b1;
              state_q <= S_COMPARE;
            end
          end
          S_COMPARE: begin
            // Comparator has settled on guess_q/secret_q during this cycle.
            busy_q      <= 1'b0;
            rv_q        <= 1'b1;
            tries_q     <= tries_d;
            hint_high_q <= cmp_gt;
            hint_low_q  <= cmp_lt;
            if (!onehot_d) begin
              err_q <= 1'b1;
            end
            if (cmp_eq && onehot_d) begin
              win_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (last_try_d) begin
              lose_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_ARMED;
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign cmp_a        = guess_q;
  assign cmp_b        = secret_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign hint_high    = hint_high_q;
  assign hint_low     = hint_low_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign tries        = tries_q;
  assign cmp_err      = err_q;

endmodule

// File: tb/tb_guess_evaluator.sv
// Directed bench for guess_evaluator: behavioural comparator models, a result
// scoreboard for the default instance and a second MAX_TRIES=3 instance for
// the lose path.
`timescale 1ns/1ps
module tb_guess_evaluator;

  typedef struct packed {
    logic       hh;
    logic       hl;
    logic       win;
    logic       lose;
    logic [3:0] tries;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       load_secret;
  logic [3:0] secret_in;
  logic       guess_valid;
  logic [3:0] guess_in;
  logic       bad;

  logic [3:0] cmp_a, cmp_b;
  logic       cmp_eq, cmp_gt, cmp_lt;
  logic       busy, result_valid, hint_high, hint_low, win, lose, cmp_err;
  logic [3:0] tries;

  logic [3:0] cmp_a3, cmp_b3;
  logic       cmp_eq3, cmp_gt3, cmp_lt3;
  logic       busy3, rv3, hh3, hl3, win3, lose3, err3;
  logic [3:0] tries3;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [3:0] m_secret;
  logic [3:0] m_tries;
  logic       m_err;

  guess_evaluator dut (
    .clk(clk), .rst(rst), .load_secret(load_secret), .secret_in(secret_in),
    .guess_valid(guess_valid), .guess_in(guess_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
    .busy(busy), .result_valid(result_valid), .hint_high(hint_high), .hint_low(hint_low),
    .win(win), .lose(lose), .tries(tries), .cmp_err(cmp_err)
  );

  guess_evaluator #(.MAX_TRIES(3)) dut3 (
    .clk(clk), .rst(rst), .load_secret(load_secret), .secret_in(secret_in),
    .guess_valid(guess_valid), .guess_in(guess_in),
    .cmp_a(cmp_a3), .cmp_b(cmp_b3), .cmp_eq(cmp_eq3), .cmp_gt(cmp_gt3), .cmp_lt(cmp_lt3),
    .busy(busy3), .result_valid(rv3), .hint_high(hh3), .hint_low(hl3),
    .win(win3), .lose(lose3), .tries(tries3), .cmp_err(err3)
  );

  // Behavioural comparators; 'bad' forces the illegal eq=gt=1 pattern.
  always_comb begin
    cmp_eq  = bad ? 1'b1 : (cmp_a == cmp_b);
    cmp_gt  = bad ? 1'b1 : (cmp_a > cmp_b);
    cmp_lt  = bad ? 1'b0 : (cmp_a < cmp_b);
    cmp_eq3 = bad ? 1'b1 : (cmp_a3 == cmp_b3);
    cmp_gt3 = bad ? 1'b1 : (cmp_a3 > cmp_b3);
    cmp_lt3 = bad ? 1'b0 : (cmp_a3 < cmp_b3);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every result_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rv_unexpected", 32'(result_valid), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'({hint_high, hint_low, win, lose, tries, cmp_err}), 32'(mon_e));
      end
    end
  end

  task automatic load(input logic [3:0] s);
    load_secret = 1'b1;
    secret_in   = s;
    m_secret    = s;
    m_tries     = 4'd0;
    m_err       = 1'b0;
    @(negedge clk);
    load_secret = 1'b0;
  endtask

  task automatic guess(input logic [3:0] g, input logic b);
    exp_t e;
    bad         = b;
    guess_valid = 1'b1;
    guess_in    = g;
    m_tries     = m_tries + 4'd1;
    if (b) m_err = 1'b1;
    e.hh    = b ? 1'b1 : (g > m_secret);
    e.hl    = b ? 1'b0 : (g < m_secret);
    e.win   = !b && (g == m_secret);
    e.lose  = !e.win && (m_tries == 4'd7);
    e.tries = m_tries;
    e.err   = m_err;
    sb.push_back(e);
    @(negedge clk);
    guess_valid = 1'b0;
    chk("busy_in_compare", 32'(busy), 32'(1));
    chk("cmp_a_latched", 32'(cmp_a), 32'(g));
    @(negedge clk);
    bad = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; load_secret = 1'b0; secret_in = 4'd0;
    guess_valid = 1'b0; guess_in = 4'd0; bad = 1'b0;
    m_secret = 4'd0; m_tries = 4'd0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({cmp_a, cmp_b, tries, busy, result_valid, hint_high, hint_low, win, lose, cmp_err}), 32'(0));
    rst = 1'b0;

    // IDLE ignores guesses
    guess_valid = 1'b1; guess_in = 4'd3;
    repeat (2) @(negedge clk);
    guess_valid = 1'b0;
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_cmp_a", 32'(cmp_a), 32'(0));

    // Round 1: immediate win, then DONE holds
    load(4'd9);
    chk("load_cmp_b", 32'(cmp_b), 32'(9));
    chk("load_cmp_a", 32'(cmp_a), 32'(0));
    guess(4'd9, 1'b0);
    chk("win_rv", 32'(result_valid), 32'(1));
    guess_valid = 1'b1; guess_in = 4'd3;
    repeat (3) @(negedge clk);
    guess_valid = 1'b0;
    chk("done_hold", 32'({cmp_a, win, tries, busy}), 32'({4'd9, 1'b1, 4'd1, 1'b0}));

    // Round 2: high, low, win at back-to-back throughput
    load(4'd5);
    guess(4'd12, 1'b0);
    chk("hint_high_first", 32'(hint_high), 32'(1));
    guess(4'd2, 1'b0);
    chk("hint_low_second", 32'(hint_low), 32'(1));
    guess(4'd5, 1'b0);
    chk("round2_lose", 32'(lose), 32'(0));

    // Round 3: three misses exhaust the MAX_TRIES=3 instance
    load(4'd0);
    guess(4'd1, 1'b0);
    guess(4'd2, 1'b0);
    guess(4'd3, 1'b0);
    chk("dut3_lose", 32'({lose3, win3, tries3}), 32'({1'b1, 1'b0, 4'd3}));
    load(4'd4);
    chk("dut3_cleared", 32'({lose3, win3, tries3}), 32'(0));
    chk("hints_cleared", 32'({hint_high, hint_low}), 32'(0));

    // guess_valid held through the busy cycle: second value dropped
    guess_valid = 1'b1; guess_in = 4'd7;
    m_tries = m_tries + 4'd1;
    e.hh = 1'b1; e.hl = 1'b0; e.win = 1'b0; e.lose = 1'b0; e.tries = m_tries; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    guess_in = 4'd4;
    @(negedge clk);
    guess_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_drop_tries", 32'(tries), 32'(1));
    chk("busy_drop_cmp_a", 32'(cmp_a), 32'(7));

    // Simultaneous load_secret and guess_valid: load wins
    guess_valid = 1'b1; guess_in = 4'd8;
    load(4'd8);
    guess_valid = 1'b0;
    chk("simul_state", 32'({cmp_a, cmp_b, tries, busy}), 32'({4'd0, 4'd8, 4'd0, 1'b0}));
    repeat (2) @(negedge clk);
    chk("simul_no_busy", 32'(busy), 32'(0));

    // load_secret in COMPARE abandons the evaluation
    guess_valid = 1'b1; guess_in = 4'd3;
    @(negedge clk);
    guess_valid = 1'b0;
    load(4'd8);
    chk("abandon", 32'({busy, result_valid, tries, cmp_a}), 32'(0));
    repeat (2) @(negedge clk);

    // Malformed comparator output
    guess(4'd2, 1'b1);
    chk("err_set", 32'({cmp_err, win, hint_high}), 32'({1'b1, 1'b0, 1'b1}));
    guess(4'd8, 1'b0);
    chk("err_sticky", 32'({cmp_err, win, tries}), 32'({1'b1, 1'b1, 4'd2}));
    load(4'd1);
    chk("err_cleared", 32'({cmp_err, win, tries}), 32'(0));

    // Asynchronous reset during COMPARE
    guess_valid = 1'b1; guess_in = 4'd6;
    @(negedge clk);
    guess_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    chk("async_rst", 32'({cmp_a, cmp_b, tries, busy, result_valid, hint_high, hint_low, win, lose, cmp_err}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    guess_valid = 1'b1; guess_in = 4'd1;
    repeat (2) @(negedge clk);
    guess_valid = 1'b0;
    chk("post_rst_idle", 32'({busy, cmp_a, tries}), 32'(0));
    load(4'd1);
    guess(4'd1, 1'b0);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
